cmp_pipe: RTL and testbench
===========================

// Module: cmp_pipe
// PURPOSE
//  Parametrised, pipelined set-on-compare unit; successor to the single-bit
//  SLTU flag combiner. Takes two WIDTH-bit operands plus a mode and subtracts
//  internally. Returns a zero-extended 0/1 result for SLT/SLTU/SLE/SLEU/EQ/NE.
//  Sits beside the ALU as a 2-stage valid/ready unit, with a tag carried
//  through for writeback.
// PARAMETERS
//  WIDTH  32  operand/result width (>=2)
//  TAG_W  5   width of opaque tag passed input->output (e.g. dest reg)
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  in_valid   in   1       operand beat valid
//  in_ready   out  1       unit accepts beat this cycle
//  in_a       in   WIDTH   operand A (minuend)
//  in_b       in   WIDTH   operand B (subtrahend)
//  in_mode    in   3       cmp_mode_t: SLT=0 SLTU=1 SLE=2 SLEU=3 EQ=4 NE=5
//  in_tag     in   TAG_W   opaque tag
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_result out  WIDTH   {WIDTH-1 zeros, bit}; bits [WIDTH-1:1] always 0
//  out_tag    out  TAG_W   tag of this result
//  out_err    out  1       in_mode was 6/7 (reserved); result forced 0
// BEHAVIOUR
//  - Reset (reset_n=0, async assert, sync release): s1_valid=s2_valid=0,
//    out_valid=0, out_result=0, out_tag=0, out_err=0. Beats in flight are
//    dropped. in_ready=1 while in reset and in the first cycle after.
//  - Handshake: beat transfers when valid&ready on the same edge. Once
//    out_valid is raised, out_result/out_tag/out_err hold until
//    out_valid&out_ready. in_ready does not depend combinationally on
//    in_valid.
//  - Stage 1 (on accept): diff = in_a - in_b as in_a + ~in_b + 1.
//    Register N=diff[W-1], Z=(diff==0), C=carry-out of WIDTH-bit add,
//    V=(a[W-1]^b[W-1])&(a[W-1]^diff[W-1]), plus mode and tag.
//  - Stage 2: bit = SLT:N^V  SLTU:~C  SLE:(N^V)|Z  SLEU:~C|Z  EQ:Z  NE:~Z.
//  - Latency: accept at edge k -> out_valid at edge k+2 with no stall.
//    Throughput: 1 beat/cycle.
//  - Advance rules: s2 loads when !s2_valid | out_ready.
//    s1 loads when !s1_valid | s2 loads.
//    in_ready = !s1_valid | (!s2_valid | out_ready).
//  - Full stall (both stages valid, out_ready=0): in_ready=0, all state holds.
//  - Simultaneous pop of s2 and push into s1 on the same edge: both occur,
//    no bubble, no loss.
//  - Order: strictly FIFO; no reordering or duplication.
//  - Boundaries: operands 0/0, max/max, and MSB-set cases all follow the
//    flag rules above. The carry is taken from the WIDTH-bit add (no
//    WIDTH+1 sign extension). Reserved mode: out_err=1, bit=0.
// STRUCTURE
//  - cmp_pkg: typedef enum logic [2:0] cmp_mode_t; typedef struct packed
//    {n,z,c,v} cmp_flags_t; function cmp_sel(flags, mode) for the bench
//    model.
//  - Sub-module cmp_flag_sub #(WIDTH): combinational subtract -> cmp_flags_t.
//    cmp_pipe holds the two pipeline registers, handshake and stage-2 select.
// TESTING (WIDTH=32, TAG_W=5)
//  - SLT a=0xFFFFFFFF b=1 -> result 1; SLTU same operands -> 0; tags kept.
//  - Overflow: SLT a=0x80000000 b=1 -> 1 (N=0,V=1); SLT a=0x7FFFFFFF
//    b=0xFFFFFFFF -> 0 (N=1,V=1).
//  - EQ/SLE/SLEU a=b=0x1234 -> 1/1/1; NE -> 0; mode 7 -> out_err=1, result 0.
//  - Back-to-back 8 beats, out_ready=1 -> first out_valid 2 cycles after
//    first accept, then 8 consecutive results in order.
//  - Stall: out_ready=0 for 5 cycles with 4 beats offered -> exactly 2
//    accepted, in_ready=0, output held stable; release -> remaining beats
//    drain in order, none lost.
//  - reset_n pulsed low mid-stream (async, off-edge) -> out_valid=0 and
//    out_result=0 immediately; old beats are never emitted after release.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the pipelined set-on-compare unit.
package cmp_pkg;

    typedef enum logic [2:0] {
        CMP_SLT  = 3'd0,
        CMP_SLTU = 3'd1,
        CMP_SLE  = 3'd2,
        CMP_SLEU = 3'd3,
        CMP_EQ   = 3'd4,
        CMP_NE   = 3'd5
    } cmp_mode_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } cmp_flags_t;

    // Encodings 6 and 7 are reserved and flag an error downstream.
    function automatic logic cmp_mode_rsvd(input logic [2:0] mode);
        return (mode > 3'd5);
    endfunction

    // Map subtract flags to the compare bit; reserved modes yield 0.
    function automatic logic cmp_sel(input cmp_flags_t f, input logic [2:0] mode);
        logic bit_o;
        bit_o = 1'b0;
        case (mode)
            CMP_SLT:  bit_o = f.n ^ f.v;
            CMP_SLTU: bit_o = ~f.c;
            CMP_SLE:  bit_o = (f.n ^ f.v) | f.z;
            CMP_SLEU: bit_o = ~f.c | f.z;
            CMP_EQ:   bit_o = f.z;
            CMP_NE:   bit_o = ~f.z;
            default:  bit_o = 1'b0;
        endcase
        return bit_o;
    endfunction

endpackage

// File: rtl/cmp_flag_sub.sv
// Combinational a - b producing N/Z/C/V flags from a single WIDTH-bit add.
module cmp_flag_sub
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_flags_t       flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;

    // a + ~b + 1; carry-out is bit WIDTH of the unextended add (C=1 means no borrow).
    always_comb begin
        sum     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        diff    = sum[WIDTH-1:0];
        flags.n = diff[WIDTH-1];
        flags.z = (diff == '0);
        flags.c = sum[WIDTH];
        flags.v = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]);
    end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage valid/ready set-on-compare unit: stage 1 registers subtract
// flags, stage 2 registers the selected bit, error and tag for writeback.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    cmp_flags_t       flags;
    logic             s1_valid;
    cmp_flags_t       s1_flags;
    logic [2:0]       s1_mode;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic             s2_bit;
    logic             s2_err;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_load;
    logic             s1_load;

    cmp_flag_sub #(.WIDTH(WIDTH)) u_flag_sub (
        .a     (in_a),
        .b     (in_b),
        .flags (flags)
    );

    // Ready chains back from the output; never depends on in_valid.
    always_comb begin
        s2_load  = ~s2_valid | out_ready;
        s1_load  = ~s1_valid | s2_load;
        in_ready = s1_load;
    end

    // Stage 1: capture flags, mode and tag of an accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_flags <= '0;
            s1_mode  <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_flags <= flags;
                s1_mode  <= in_mode;
                s1_tag   <= in_tag;
            end
        end
    end

    // Stage 2: select the compare bit; contents hold while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_bit   <= 1'b0;
            s2_err   <= 1'b0;
            s2_tag   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_bit <= cmp_sel(s1_flags, s1_mode);
                s2_err <= cmp_mode_rsvd(s1_mode);
                s2_tag <= s1_tag;
            end
        end
    end

    // Result is zero-extended to WIDTH.
    always_comb begin
        out_valid  = s2_valid;
        out_result = {{(WIDTH-1){1'b0}}, s2_bit};
        out_tag    = s2_tag;
        out_err    = s2_err;
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed bench for cmp_pipe: modes, overflow, reserved, throughput, stall, reset.
module tb_cmp_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        err;
        int          cyc;
    } obs_t;

    obs_t q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  mode;
        logic [4:0]  tag;
        logic        exp_bit;
        logic        exp_err;
    } vec_t;

    cmp_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result that will be popped on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready)
            q.push_back('{out_result, out_tag, out_err, cyc});
    end

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] mode, input logic [4:0] tag);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_mode = mode;
        in_tag = tag;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout tag=%0d in_ready never rose", tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 40; i++) begin
            if (q.size() >= n) break;
            @(negedge clk);
        end
        if (q.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL result_timeout got=%0d want=%0d", q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = '0; in_b = '0; in_mode = '0; in_tag = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'h0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b r=%h t=%h e=%b want 0/0/0/0",
                     out_valid, out_result, out_tag, out_err);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        vec_t v[13];
        obs_t o;
        v[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 5'd3,  1'b1, 1'b0};
        v[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd1, 5'd4,  1'b0, 1'b0};
        v[2]  = '{32'h8000_0000, 32'h0000_0001, 3'd0, 5'd5,  1'b1, 1'b0};
        v[3]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd0, 5'd6,  1'b0, 1'b0};
        v[4]  = '{32'h0000_1234, 32'h0000_1234, 3'd4, 5'd7,  1'b1, 1'b0};
        v[5]  = '{32'h0000_1234, 32'h0000_1234, 3'd2, 5'd8,  1'b1, 1'b0};
        v[6]  = '{32'h0000_1234, 32'h0000_1234, 3'd3, 5'd9,  1'b1, 1'b0};
        v[7]  = '{32'h0000_1234, 32'h0000_1234, 3'd5, 5'd10, 1'b0, 1'b0};
        v[8]  = '{32'h0000_1234, 32'h0000_1234, 3'd7, 5'd11, 1'b0, 1'b1};
        v[9]  = '{32'h0000_0000, 32'h0000_0000, 3'd0, 5'd12, 1'b0, 1'b0};
        v[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 5'd13, 1'b0, 1'b0};
        v[11] = '{32'h0000_0000, 32'hFFFF_FFFF, 3'd1, 5'd14, 1'b1, 1'b0};
        v[12] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'd2, 5'd15, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            q.delete();
            send_beat(v[i].a, v[i].b, v[i].mode, v[i].tag);
            wait_results(1);
            if (q.size() > 0) begin
                o = q.pop_front();
                n_checks++;
                if (o.res !== {31'h0, v[i].exp_bit} || o.tag !== v[i].tag || o.err !== v[i].exp_err) begin
                    n_fail++;
                    $display("FAIL directed[%0d] got r=%h t=%0d e=%b want r=%h t=%0d e=%b",
                             i, o.res, o.tag, o.err, {31'h0, v[i].exp_bit}, v[i].tag, v[i].exp_err);
                end
            end
            repeat (2) @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int acc_cyc;
        obs_t o;
        logic exp_bit;
        out_ready = 1'b1;
        q.delete();
        acc_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_a = 32'(i);
            in_b = 32'd4;
            in_mode = 3'd1;
            in_tag = 5'(16 + i);
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready beat=%0d got=%b want=1", i, in_ready);
            end
            if (i == 0) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_results(8);
        n_checks++;
        if (q.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d want=8", q.size());
        end
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            o = q.pop_front();
            exp_bit = (i < 4);
            n_checks++;
            if (o.res !== {31'h0, exp_bit} || o.tag !== 5'(16 + i) || o.cyc != acc_cyc + 2 + i) begin
                n_fail++;
                $display("FAIL b2b[%0d] got r=%h t=%0d cyc=%0d want r=%h t=%0d cyc=%0d",
                         i, o.res, o.tag, o.cyc, {31'h0, exp_bit}, 16 + i, acc_cyc + 2 + i);
            end
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int acc;
        int j;
        obs_t o;
        logic exp_bits [4];
        exp_bits[0] = 1'b1; exp_bits[1] = 1'b1; exp_bits[2] = 1'b0; exp_bits[3] = 1'b0;
        out_ready = 1'b0;
        q.delete();
        acc = 0;
        j = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = 32'(j); in_b = 32'd1; in_mode = 3'd3; in_tag = 5'(10 + j);
            @(negedge clk);
            if (in_ready) begin
                acc++;
                j++;
            end
            if (i >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_result !== 32'h1 || out_tag !== 5'd10 || out_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d got v=%b r=%h t=%0d want 1/1/10", i, out_valid, out_result, out_tag);
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (acc != 2) begin
            n_fail++;
            $display("FAIL stall_accepted got=%0d want=2", acc);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && j < 4; i++) begin
            in_valid = 1'b1;
            in_a = 32'(j); in_b = 32'd1; in_mode = 3'd3; in_tag = 5'(10 + j);
            @(negedge clk);
            if (in_ready) j++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_results(4);
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            o = q.pop_front();
            n_checks++;
            if (o.res !== {31'h0, exp_bits[i]} || o.tag !== 5'(10 + i)) begin
                n_fail++;
                $display("FAIL stall_drain[%0d] got r=%h t=%0d want r=%h t=%0d",
                         i, o.res, o.tag, {31'h0, exp_bits[i]}, 10 + i);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_extra got=%0d extra results want=0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        obs_t o;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a = 32'd0; in_b = 32'd1; in_mode = 3'd0; in_tag = 5'(20 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h1) begin
            n_fail++;
            $display("FAIL pre_reset_full got v=%b r=%h want 1/1", out_valid, out_result);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset got v=%b r=%h t=%0d rdy=%b want 0/0/0/1",
                     out_valid, out_result, out_tag, in_ready);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        q.delete();
        repeat (6) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_ghost got=%0d stale results want=0", q.size());
        end
        @(posedge clk);
        #1;
        send_beat(32'd5, 32'd9, 3'd0, 5'd22);
        wait_results(1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() != 1) begin
            n_fail++;
            $display("FAIL post_reset_count got=%0d want=1", q.size());
        end
        if (q.size() > 0) begin
            o = q.pop_front();
            n_checks++;
            if (o.tag !== 5'd22 || o.res !== 32'h1) begin
                n_fail++;
                $display("FAIL post_reset_beat got r=%h t=%0d want r=1 t=22", o.res, o.tag);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
